// File: rtl/vx_gfx_dcr_dispatch_pkg.sv
// Shared definitions for the graphics DCR dispatcher: default bus widths,
// channel indices and the packed address ranges used by the cluster.
package vx_gfx_dcr_dispatch_pkg;

    localparam int DCR_ADDR_WIDTH = 12;
    localparam int DCR_DATA_WIDTH = 32;

    // Destination channel indices.
    localparam int GFX_DCR_CH_RASTER = 0;
    localparam int GFX_DCR_CH_TEX    = 1;
    localparam int GFX_DCR_CH_OM     = 2;
    localparam int GFX_DCR_NUM_CH    = 3;

    // Per-unit DCR state windows (begin inclusive, end exclusive).
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_RASTER_STATE_BEGIN = 12'h001;
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_RASTER_STATE_END   = 12'h00A;
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_STATE_BEGIN    = 12'h00A;
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_STATE_END      = 12'h01A;
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_OM_STATE_BEGIN     = 12'h01A;
    localparam logic [DCR_ADDR_WIDTH-1:0] DCR_OM_STATE_END       = 12'h02A;

    // Packed range tables for the cluster instance; channel i at slice i.
    localparam logic [GFX_DCR_NUM_CH*DCR_ADDR_WIDTH-1:0] GFX_DCR_RANGE_BEGIN =
        {DCR_OM_STATE_BEGIN, DCR_TEX_STATE_BEGIN, DCR_RASTER_STATE_BEGIN};
    localparam logic [GFX_DCR_NUM_CH*DCR_ADDR_WIDTH-1:0] GFX_DCR_RANGE_END =
        {DCR_OM_STATE_END, DCR_TEX_STATE_END, DCR_RASTER_STATE_END};

    // Half-open range test on zero-extended addresses.
    function automatic logic dcr_in_range(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/vx_gfx_dcr_dispatch_if.sv
// DCR write bus bundle: LANES parallel valid/ready write lanes.
interface vx_gfx_dcr_dispatch_if
    import vx_gfx_dcr_dispatch_pkg::*;
#(
    parameter int LANES = 1,
    parameter int AW    = DCR_ADDR_WIDTH,
    parameter int DW    = DCR_DATA_WIDTH
);
    logic [LANES-1:0]    valid;
    logic [LANES*AW-1:0] addr;
    logic [LANES*DW-1:0] data;
    logic [LANES-1:0]    ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/vx_gfx_dcr_dispatch_fifo.sv
// Per-channel write queue. The head is read asynchronously so a write pushed
// into an empty queue is visible the next cycle and pops stream without bubbles.
module vx_gfx_dcr_dispatch_fifo #(
    parameter int DATAW = 44,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic [DATAW-1:0] head_data,
    output logic             not_empty,
    output logic [CNT_W-1:0] count
);
    logic [DATAW-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage needs no reset: entries are only observed behind the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;
endmodule

// File: rtl/vx_gfx_dcr_dispatch.sv
// Decodes DCR writes against programmable ranges, queues them per destination
// unit and delivers them with backpressure and an optional busy fence.
module vx_gfx_dcr_dispatch
    import vx_gfx_dcr_dispatch_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int ADDR_WIDTH   = DCR_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DCR_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] RANGE_BEGIN = '0,
    parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] RANGE_END   = '0,
    parameter logic [NUM_CHANNELS-1:0]            FENCE_MASK  = '0,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    vx_gfx_dcr_dispatch_if.slave              in_write,
    vx_gfx_dcr_dispatch_if.master             out_write,
    input  logic [NUM_CHANNELS-1:0]           unit_busy,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0] pending,
    output logic [15:0]                       miss_count,
    output logic                              idle
);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic [NUM_CHANNELS-1:0]            match;
    logic [NUM_CHANNELS-1:0]            has_room;
    logic [NUM_CHANNELS-1:0]            push;
    logic [NUM_CHANNELS-1:0]            pop;
    logic [NUM_CHANNELS-1:0]            not_empty;
    logic [NUM_CHANNELS-1:0]            out_valid;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0] out_addr;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data;
    logic                               any_match;
    logic                               in_ready;
    logic                               accept;
    logic [15:0]                        miss_count_reg;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [ENTRY_W-1:0] head;

            assign match[gi] = dcr_in_range(32'(in_write.addr),
                                            32'(RANGE_BEGIN[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                                            32'(RANGE_END[gi*ADDR_WIDTH +: ADDR_WIDTH]));
            // Fullness is judged on start-of-cycle occupancy only, so the
            // sink's ready never reaches in_write.ready.
            assign has_room[gi]  = pending[gi*CNT_WIDTH +: CNT_WIDTH] < CNT_WIDTH'(FIFO_DEPTH);
            assign push[gi]      = accept && match[gi];
            assign out_valid[gi] = not_empty[gi] && !(FENCE_MASK[gi] && unit_busy[gi]);
            assign pop[gi]       = out_valid[gi] && out_write.ready[gi];

            vx_gfx_dcr_dispatch_fifo #(
                .DATAW (ENTRY_W),
                .DEPTH (FIFO_DEPTH)
            ) queue (
                .clk       (clk),
                .reset     (reset),
                .push      (push[gi]),
                .push_data ({in_write.addr, in_write.data}),
                .pop       (pop[gi]),
                .head_data (head),
                .not_empty (not_empty[gi]),
                .count     (pending[gi*CNT_WIDTH +: CNT_WIDTH])
            );

            assign out_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = head[ENTRY_W-1 -: ADDR_WIDTH];
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
        end
    endgenerate

    // A write is taken only when every matched queue can hold it, so a
    // broadcast never lands in a subset of its channels. Unmatched writes
    // are always taken (and dropped).
    assign any_match = |match;
    assign in_ready  = &(~match | has_room);
    assign accept    = in_write.valid && in_ready;

    assign in_write.ready  = in_ready;
    assign out_write.valid = out_valid;
    assign out_write.addr  = out_addr;
    assign out_write.data  = out_data;

    // Count writes that hit no channel, holding at the maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_count_reg <= '0;
        end else if (in_write.valid && !any_match && (miss_count_reg != 16'hFFFF)) begin
            miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign miss_count = miss_count_reg;
    assign idle       = (pending == '0);
endmodule

// File: tb/tb_vx_gfx_dcr_dispatch.sv
// Scoreboard bench for vx_gfx_dcr_dispatch: stimulus pushes expected writes
// per channel, a monitor pops and compares every delivered write.
module tb_vx_gfx_dcr_dispatch;
    import vx_gfx_dcr_dispatch_pkg::*;

    localparam int NCH   = 3;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = 3;
    // ch0 [0x000,0x00C), ch1 [0x010,0x020), ch2 [0x008,0x010): ch0/ch2 overlap at 0x008..0x00B
    localparam logic [NCH*AW-1:0] RB = {12'h008, 12'h010, 12'h000};
    localparam logic [NCH*AW-1:0] RE = {12'h010, 12'h020, 12'h00C};
    localparam logic [NCH-1:0]    FM = 3'b100;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    unit_busy;
    logic [NCH*PW-1:0] pending;
    logic [15:0]       miss_count;
    logic              idle;

    vx_gfx_dcr_dispatch_if #(.LANES(1),   .AW(AW), .DW(DW)) in_write ();
    vx_gfx_dcr_dispatch_if #(.LANES(NCH), .AW(AW), .DW(DW)) out_write ();

    vx_gfx_dcr_dispatch #(
        .NUM_CHANNELS (NCH),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .RANGE_BEGIN  (RB),
        .RANGE_END    (RE),
        .FENCE_MASK   (FM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_write   (in_write),
        .out_write  (out_write),
        .unit_busy  (unit_busy),
        .pending    (pending),
        .miss_count (miss_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW+DW-1:0] exp_q [NCH][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called on a negedge; holds the write until accepted (bounded), records
    // the expected deliveries, returns on the negedge after acceptance.
    task automatic write_req(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [NCH-1:0] mask);
        int waited = 0;
        in_write.valid = 1'b1;
        in_write.addr  = addr;
        in_write.data  = data;
        #3;
        while (!in_write.ready && waited < 40) begin
            @(negedge clk);
            #3;
            waited++;
        end
        check($sformatf("accept_%03h", addr), 64'(in_write.ready), 64'(1));
        if (in_write.ready) begin
            for (int i = 0; i < NCH; i++) begin
                if (mask[i]) exp_q[i].push_back({addr, data});
            end
        end
        @(negedge clk);
        in_write.valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        #2;
        while (!idle && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(name, 64'(idle), 64'(1));
        @(negedge clk);
    endtask

    // Monitor: sample just before each rising edge and score every handshake.
    initial begin : monitor
        logic [AW+DW-1:0] got;
        logic [AW+DW-1:0] expv;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                for (int i = 0; i < NCH; i++) begin
                    if (out_write.valid[i] && out_write.ready[i]) begin
                        got = {out_write.addr[i*AW +: AW], out_write.data[i*DW +: DW]};
                        $display("ch%0d write addr=%03h data=%08h", i, got[AW+DW-1 -: AW], got[DW-1:0]);
                        if (exp_q[i].size() == 0) begin
                            n_checks++;
                            $display("FAIL ch%0d_unexpected: got %0h expected none", i, got);
                        end else begin
                            expv = exp_q[i].pop_front();
                            check($sformatf("ch%0d_write", i), 64'(got), 64'(expv));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset          = 1'b1;
        unit_busy      = '0;
        in_write.valid = 1'b0;
        in_write.addr  = '0;
        in_write.data  = '0;
        out_write.ready = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_valid", 64'(out_write.valid), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_miss", 64'(miss_count), 64'(0));
        check("rst_in_ready", 64'(in_write.ready), 64'(1));
        @(negedge clk);

        // Single write to the tex channel shows up the next cycle.
        out_write.ready = '1;
        write_req(12'h012, 32'h0000CAFE, 3'b010);
        #2;
        check("t1_valid", 64'(out_write.valid), 64'(3'b010));
        check("t1_addr", 64'(out_write.addr[AW +: AW]), 64'(12'h012));
        check("t1_data", 64'(out_write.data[DW +: DW]), 64'(32'h0000CAFE));
        wait_idle("t1_idle");

        // Fill channel 0, fifth write blocked until a slot frees.
        out_write.ready = 3'b110;
        for (int k = 0; k < 4; k++) write_req(12'(k), 32'h100 + 32'(k), 3'b001);
        #2;
        check("t2_pending0_full", 64'(pending[0 +: PW]), 64'(4));
        check("t2_ready_idle_full", 64'(in_write.ready), 64'(0));
        @(negedge clk);
        in_write.valid = 1'b1;
        in_write.addr  = 12'h004;
        in_write.data  = 32'h104;
        #3;
        check("t2_full_block", 64'(in_write.ready), 64'(0));
        out_write.ready[0] = 1'b1;
        @(negedge clk);
        write_req(12'h004, 32'h104, 3'b001);
        wait_idle("t2_idle");

        // Overlap write blocked by full ch2; no partial push into ch0.
        out_write.ready = 3'b000;
        for (int k = 0; k < 4; k++) write_req(12'h00C + 12'(k), 32'h200 + 32'(k), 3'b100);
        #2;
        check("t3_pending2_full", 64'(pending[2*PW +: PW]), 64'(4));
        @(negedge clk);
        in_write.valid = 1'b1;
        in_write.addr  = 12'h008;
        in_write.data  = 32'h2AA;
        #3;
        check("t3_overlap_block", 64'(in_write.ready), 64'(0));
        @(negedge clk);
        #1;
        check("t3_no_partial0", 64'(pending[0 +: PW]), 64'(0));
        out_write.ready[2] = 1'b1;
        @(negedge clk);
        out_write.ready[2] = 1'b0;
        write_req(12'h008, 32'h2AA, 3'b101);
        #2;
        check("t3_both_pend0", 64'(pending[0 +: PW]), 64'(1));
        check("t3_both_pend2", 64'(pending[2*PW +: PW]), 64'(4));
        out_write.ready = '1;
        wait_idle("t3_idle");

        // Fence: busy unit 2 holds its queued write.
        unit_busy = 3'b100;
        write_req(12'h00D, 32'h300, 3'b100);
        #2;
        check("t4_pending2", 64'(pending[2*PW +: PW]), 64'(1));
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t4_fenced_c%0d", c), 64'(out_write.valid[2]), 64'(0));
            @(negedge clk);
            #2;
        end
        unit_busy = 3'b000;
        #1;
        check("t4_fence_open", 64'(out_write.valid[2]), 64'(1));
        wait_idle("t4_idle");

        // Unmapped writes count as misses and saturate.
        for (int k = 0; k < 3; k++) begin
            write_req(12'hFFF, 32'(k), 3'b000);
            #2;
            check($sformatf("t5_no_valid_%0d", k), 64'(out_write.valid), 64'(0));
            @(negedge clk);
        end
        check("t5_miss3", 64'(miss_count), 64'(3));
        force dut.miss_count_reg = 16'hFFFF;
        #1;
        release dut.miss_count_reg;
        @(negedge clk);
        write_req(12'hFFF, 32'h5A5A, 3'b000);
        #2;
        check("t5_miss_sat", 64'(miss_count), 64'(16'hFFFF));
        check("sb_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
        @(negedge clk);

        // Reset flushes populated queues.
        out_write.ready = '0;
        write_req(12'h000, 32'h600, 3'b001);
        write_req(12'h001, 32'h601, 3'b001);
        write_req(12'h010, 32'h610, 3'b010);
        write_req(12'h00C, 32'h620, 3'b100);
        write_req(12'h00D, 32'h621, 3'b100);
        write_req(12'h00E, 32'h622, 3'b100);
        #2;
        check("t6_pending", 64'(pending), 64'({3'd3, 3'd1, 3'd2}));
        check("t6_not_idle", 64'(idle), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("t6_rst_pending", 64'(pending), 64'(0));
        check("t6_rst_valid", 64'(out_write.valid), 64'(0));
        check("t6_rst_idle", 64'(idle), 64'(1));
        check("t6_rst_miss", 64'(miss_count), 64'(0));
        for (int i = 0; i < NCH; i++) exp_q[i].delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fresh traffic after reset: stale entries would surface as extra writes.
        out_write.ready = '1;
        write_req(12'h012, 32'h0000BEEF, 3'b010);
        write_req(12'h009, 32'h0000F00D, 3'b101);
        wait_idle("t6_post_idle");
        check("t6_sb_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vx_gfx_dcr_dispatch.md
# vx_gfx_dcr_dispatch

Parametrised DCR write dispatcher for the cluster graphics block. It replaces the fixed, unbuffered per-extension DCR address filters (raster, tex, om, and future units) with one block. The block decodes each DCR write against NUM_CHANNELS programmable address ranges and queues it per channel. It delivers writes with valid/ready backpressure, and can optionally hold a channel's writes until that unit reports idle, so state never changes under in-flight work.

## Interface
Parameters:
- NUM_CHANNELS, 3, number of destination units (1..8)
- ADDR_WIDTH, `VX_DCR_ADDR_WIDTH, DCR address width
- DATA_WIDTH, `VX_DCR_DATA_WIDTH, DCR data width
- FIFO_DEPTH, 4, per-channel queue depth (power of 2, ≥2)
- RANGE_BEGIN, 0, NUM_CHANNELS×ADDR_WIDTH packed; inclusive lower bound, channel i at slice i
- RANGE_END, 0, NUM_CHANNELS×ADDR_WIDTH packed; exclusive upper bound
- FENCE_MASK, 0, NUM_CHANNELS bits; bit i=1 holds channel i output while unit i is busy

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_write_valid  in  1  DCR write request
- in_write_addr  in  ADDR_WIDTH  write address
- in_write_data  in  DATA_WIDTH  write data
- in_write_ready  out  1  write accepted when valid&ready
- out_write_valid  out  NUM_CHANNELS  per-channel write valid
- out_write_addr  out  NUM_CHANNELS×ADDR_WIDTH  per-channel address
- out_write_data  out  NUM_CHANNELS×DATA_WIDTH  per-channel data
- out_write_ready  in  NUM_CHANNELS  per-channel sink ready
- unit_busy  in  NUM_CHANNELS  unit i has work in flight
- pending  out  NUM_CHANNELS×$clog2(FIFO_DEPTH+1)  queue occupancy per channel
- miss_count  out  16  saturating count of unmatched writes
- idle  out  1  all queues empty

## Operation
- Decode: match[i] = (addr ≥ RANGE_BEGIN[i]) && (addr < RANGE_END[i]). Overlapping ranges broadcast to every matching channel.
- Atomic accept: in_write_ready = AND over matched i of (pending[i] < FIFO_DEPTH). On accept, push {addr,data} into every matched queue in the same cycle; a write never enters only part of its channels.
- Unmatched write: in_write_ready=1. On valid, drop the write and increment miss_count, saturating at 16'hFFFF.
- Output i: out_write_valid[i] = queue i non-empty && !(FENCE_MASK[i] && unit_busy[i]). Head pops on valid&ready. Per-channel order is FIFO.
- Fence: valid may deassert when unit_busy rises before ready. This is the one sanctioned exception to valid-stability; addr/data stay at the head.
- pending[i] updates by +push −pop; simultaneous push and pop leaves it unchanged.
- idle = all pending[i]==0.

## Timing
- Reset values: all out_write_valid=0, pending=0, miss_count=0, idle=1. Queues are flushed, and entries in flight at reset are discarded. in_write_ready is combinational from the current address and occupancy; with no valid it reflects current fullness.
- Latency: a write accepted in cycle t shows at out_write_valid in t+1 when the queue was empty and the fence is open. Pop in t+1 allows a new head in t+2 with no bubble when back-to-back entries are queued.
- Full queue: push is blocked when pending==FIFO_DEPTH at cycle start, even if a pop occurs that cycle. There is no full-bypass, which keeps ready off the out_write_ready path.
- Back-to-back throughput is 1 write/cycle per channel when the sink is ready.
- unit_busy is sampled combinationally and gates valid in the same cycle.

## Structure
- Per-channel queue: instantiate VX_fifo_queue (DATAW=ADDR_WIDTH+DATA_WIDTH, DEPTH=FIFO_DEPTH, OUT_REG=0) once per channel in a generate loop.
- Shared package VX_gpu_pkg holds the channel index constants (GFX_DCR_CH_RASTER=0, _TEX=1, _OM=2) and packed range localparams built from `VX_DCR_*_STATE_BEGIN/END for the cluster instantiation.
- Decode, accept logic, miss counter and idle live in this module.

## Test plan
- Tex range 0x010–0x01F, channel 1 ready. Write addr 0x012 data 0xCAFE in cycle 0 → out_write_valid[1]=1 in cycle 1 with 0x012/0xCAFE; the other channels stay 0.
- Channel 0 ready held low, depth 4. Five writes to channel 0 → first four accepted, pending[0]=4, fifth sees in_write_ready=0. Raise ready → 4 pops in order, then the fifth is accepted.
- Overlapping ranges on ch0 and ch2, ch2 full. Write to the overlap → ready=0 and neither queue pushes. Free one ch2 slot → both queues push in the same cycle.
- FENCE_MASK[2]=1, unit_busy[2]=1, one queued write → valid[2]=0 for 10 cycles. Drop busy → valid[2]=1 the same cycle.
- Write to unmapped addr 0xFFF ×3 → miss_count=3 and no channel valid. Force count to 0xFFFF, one more miss → stays 0xFFFF.
- Reset asserted with pending={2,1,3} → next cycle all pending=0, valids=0, idle=1.
